fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Sequential instruction-fetch / PC stage feeding the decode/control stage.
- Holds the PC and fetches from an instruction memory with variable latency via a req/ready handshake.
- Presents each instruction to the control unit for exactly one execute cycle.
- Consumes the control outputs (is_jal, is_jalr, branch, is_ecall) plus branch/ALU results to choose and register the next PC; halts on ECALL.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction presented when no valid fetch (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; address valid while high.
- imem_addr  output  32  fetch address (= pc).
- imem_ready  input  1  instruction-memory response; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- inst  output  32  registered instruction to decode (part_of_inst = inst[6:0]).
- inst_valid  output  1  high for exactly the one EXEC cycle per instruction.
- pc  output  32  PC of the current instruction.
- pc_plus_4  output  32  pc+4, for the pc_to_reg writeback.
- is_jal  input  1  from control.
- is_jalr  input  1  from control.
- branch  input  1  from control.
- bcond  input  1  branch condition from the ALU.
- imm  input  32  sign-extended immediate from the immgen.
- alu_result  input  32  JALR target (rs1+imm).
- is_ecall  input  1  from control; already qualified by x17==10.
- is_halted  output  1  sticky halt flag.
- pc_misaligned  output  1  sticky; set when the computed next PC has bit1 set.
- retired_count  output  32  number of instructions retired.

Behaviour:
- Reset (sync, when reset=1 at the edge):
  - pc=RESET_PC, inst=NOP_INST, inst_valid=0, is_halted=0, pc_misaligned=0, retired_count=0.
  - state=RST.
  - Reset overrides every other input in the same cycle, including mid-WAIT. Any in-flight imem_ready is discarded.
- FSM states and transitions:
  - RST: imem_req=0. Next state is FETCH. Gives imem one quiet cycle after reset.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready=1: inst<=imem_rdata, next state EXEC.
    - imem_ready=0: stay in FETCH, holding req/addr stable.
    - Minimum latency is 1 cycle (ready in the same cycle as req).
  - EXEC: imem_req=0, inst_valid=1. Control and datapath evaluate combinationally this cycle. At the edge:
    - retired_count += 1, wrapping mod 2^32.
    - is_ecall=1: next state HALT, is_halted<=1, pc unchanged.
    - Otherwise pc<=next_pc, next state FETCH.
    - Throughput is therefore at most one instruction per 2 cycles.
  - HALT: imem_req=0, inst_valid=0. Terminal until reset; all inputs ignored.
- next_pc, 32-bit modular arithmetic, priority is_jalr > is_jal > (branch & bcond) > sequential:
  - jalr: alu_result & ~32'h1
  - jal: pc+imm
  - taken branch: pc+imm
  - else: pc+4
  - pc=32'hFFFF_FFFC with no jump gives next_pc=0 (wrap, no flag).
- Misalignment: if next_pc[1]=1 in EXEC (non-ecall):
  - pc<=next_pc, pc_misaligned<=1, is_halted<=1, next state HALT.
  - The instruction is still counted as retired.
- inst holds its value outside EXEC; inst_valid is never high in RST, FETCH or HALT.
- pc_plus_4 = pc+4, combinational from the registered pc.
- Datapath register/memory writes are gated by inst_valid. This block guarantees exactly one inst_valid pulse per fetched instruction.

Decomposition:
- Shared package/header:
  - fetch state encoding: RST, FETCH, EXEC, HALT (2 bits).
  - NOP_INST and default RESET_PC constants.
  - The existing opcodes.v include stays shared.
- One sub-module: next_pc_sel, the purely combinational next-PC priority mux plus misalignment detect. Top level holds the FSM, pc/inst registers and counter.

Test Plan:
- Reset then zero-latency imem (ready tied 1), program addi, addi, ecall with x17=10:
  - inst_valid pulses at cycles 2, 4, 6.
  - pc = 0, 4, 8 on those pulses.
  - Halt with pc=8, retired_count=3, imem_req=0 thereafter.
- Variable latency, ready after 3 wait cycles on each fetch:
  - imem_addr held stable throughout the wait.
  - Exactly one inst_valid per instruction; no duplicate retire.
- Control targets at pc=0x10:
  - jal, imm=-8 → next fetch addr 0x08.
  - jalr, alu_result=0x21 → next fetch addr 0x20.
  - branch, bcond=0, imm=0x40 → next fetch addr 0x14.
  - branch, bcond=1, imm=0x40 → next fetch addr 0x50.
- Priority: is_jalr=1 and branch=1, bcond=1 together → jalr target wins.
- Misaligned: jal with imm=6 from pc=0 → pc=6, pc_misaligned=1, is_halted=1, retired_count=1.
- Reset asserted mid-FETCH wait, with ready arriving the following cycle:
  - Ready is ignored.
  - pc=RESET_PC, retired_count=0.
  - One RST cycle with imem_req=0, then a fresh fetch of addr 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/PC stage: state encoding, default constants
// and the RV32I major opcodes used across the core.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_ECALL     = 7'b1110011;

    typedef struct packed {
        logic is_jal;
        logic is_jalr;
        logic branch;
        logic bcond;
    } pc_ctrl_t;

    // Only bit 1 matters: bit 0 of a JALR target is cleared before this check.
    function automatic logic pc_is_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux (jalr > jal > taken branch > pc+4)
// plus misalignment detect on the selected target.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  pc_ctrl_t    i_ctrl,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu_result,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus_imm;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_jalr_target;

    assign w_pc_plus_imm = i_pc + i_imm;
    assign w_pc_plus_4   = i_pc + 32'd4;
    assign w_jalr_target = i_alu_result & ~32'h0000_0001;

    always_comb begin
        o_next_pc = w_pc_plus_4;
        if (i_ctrl.is_jalr) begin
            o_next_pc = w_jalr_target;
        end else if (i_ctrl.is_jal) begin
            o_next_pc = w_pc_plus_imm;
        end else if (i_ctrl.branch && i_ctrl.bcond) begin
            o_next_pc = w_pc_plus_imm;
        end
    end

    assign o_misaligned = pc_is_misaligned(o_next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: fetches over a req/ready handshake, presents
// each instruction for one EXEC cycle, then registers the next PC or halts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch,
    input  logic        bcond,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        is_ecall,
    output logic        is_halted,
    output logic        pc_misaligned,
    output logic [31:0] retired_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_halted;
    logic        r_misaligned;
    logic [31:0] r_retired;

    logic        w_imem_req;
    logic        w_inst_valid;
    logic        w_fetch_done;
    logic [31:0] w_next_pc;
    logic        w_next_misaligned;
    pc_ctrl_t    w_ctrl;

    assign w_ctrl = '{is_jal: is_jal, is_jalr: is_jalr, branch: branch, bcond: bcond};

    next_pc_sel u_next_pc_sel (
        .i_pc         (r_pc),
        .i_ctrl       (w_ctrl),
        .i_imm        (imm),
        .i_alu_result (alu_result),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_next_misaligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_inst_valid = 1'b0;
        w_fetch_done = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_fetch_done = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_inst_valid = 1'b1;
                if (is_ecall || w_next_misaligned) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst <= NOP_INST;
        end else if (w_fetch_done) begin
            r_inst <= imem_rdata;
        end
    end

    // ECALL keeps the PC; a misaligned target is still committed so it is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
            r_retired    <= '0;
        end else if (w_inst_valid) begin
            r_retired <= r_retired + 32'd1;
            if (is_ecall) begin
                r_halted <= 1'b1;
            end else begin
                r_pc <= w_next_pc;
                if (w_next_misaligned) begin
                    r_misaligned <= 1'b1;
                    r_halted     <= 1'b1;
                end
            end
        end
    end

    assign imem_req      = w_imem_req;
    assign imem_addr     = r_pc;
    assign inst          = r_inst;
    assign inst_valid    = w_inst_valid;
    assign pc            = r_pc;
    assign pc_plus_4     = r_pc + 32'd4;
    assign is_halted     = r_halted;
    assign pc_misaligned = r_misaligned;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        is_jal;
    logic        is_jalr;
    logic        branch;
    logic        bcond;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        is_ecall;
    logic        is_halted;
    logic        pc_misaligned;
    logic [31:0] retired_count;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .pc            (pc),
        .pc_plus_4     (pc_plus_4),
        .is_jal        (is_jal),
        .is_jalr       (is_jalr),
        .branch        (branch),
        .bcond         (bcond),
        .imm           (imm),
        .alu_result    (alu_result),
        .is_ecall      (is_ecall),
        .is_halted     (is_halted),
        .pc_misaligned (pc_misaligned),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_QUIET = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_HALT  = 3;

    bit          m_init = 0;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ret;
    logic        m_halt;
    logic        m_mis;
    int          cyc;

    function automatic logic [31:0] target(input logic [31:0] cur);
        if (is_jalr)              return alu_result & 32'hFFFF_FFFE;
        if (is_jal)               return cur + imm;
        if (branch && bcond)      return cur + imm;
        return cur + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init  <= 1;
            m_phase <= PH_QUIET;
            m_pc    <= 32'h0;
            m_inst  <= 32'h13;
            m_ret   <= 0;
            m_halt  <= 0;
            m_mis   <= 0;
            cyc     <= 0;
        end else if (m_init) begin
            cyc <= cyc + 1;
            case (m_phase)
                PH_QUIET: m_phase <= PH_FETCH;
                PH_FETCH: if (imem_ready) begin
                    m_inst  <= imem_rdata;
                    m_phase <= PH_EXEC;
                end
                PH_EXEC: begin
                    m_ret <= m_ret + 1;
                    if (is_ecall) begin
                        m_halt  <= 1;
                        m_phase <= PH_HALT;
                    end else begin
                        m_pc <= target(m_pc);
                        if ((target(m_pc) & 32'h2) != 0) begin
                            m_mis   <= 1;
                            m_halt  <= 1;
                            m_phase <= PH_HALT;
                        end else begin
                            m_phase <= PH_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    int          vcyc[$];
    logic [31:0] vpc[$];

    always @(negedge clk) begin
        if (m_init) begin
            chk("imem_req", imem_req, m_phase == PH_FETCH);
            if (m_phase == PH_FETCH) chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", inst_valid, m_phase == PH_EXEC);
            chk("inst", inst, m_inst);
            chk("pc", pc, m_pc);
            chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
            chk("is_halted", is_halted, m_halt);
            chk("pc_misaligned", pc_misaligned, m_mis);
            chk("retired_count", retired_count, m_ret);
            if (inst_valid === 1'b1) begin
                vcyc.push_back(cyc);
                vpc.push_back(pc);
            end
        end
    end

    // ---------------- instruction memory responder ----------------
    int mem_lat    = 0;
    int rnd_lat    = 0;
    int wcnt       = 0;
    bit rand_mode  = 0;
    bit force_ready = 0;

    always @(negedge clk) begin
        if (force_ready) begin
            imem_ready = 1'b1;
            imem_rdata = $urandom;
        end else if (imem_req === 1'b1) begin
            if (wcnt >= ((mem_lat < 0) ? rnd_lat : mem_lat)) begin
                imem_ready = 1'b1;
                imem_rdata = $urandom;
                wcnt       = 0;
                rnd_lat    = $urandom_range(0, 4);
            end else begin
                imem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ready = rand_mode ? 1'($urandom % 2) : 1'b0;
            imem_rdata = $urandom;
            wcnt       = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_ctrl();
        is_ecall = 0; is_jal = 0; is_jalr = 0; branch = 0; bcond = 0;
        imm = 0; alu_result = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic exec_inst(input logic e, input logic j, input logic jr, input logic b,
                             input logic bc, input logic [31:0] im, input logic [31:0] al);
        bit seen;
        seen = 0;
        is_ecall = e; is_jal = j; is_jalr = jr; branch = b; bcond = bc;
        imm = im; alu_result = al;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("exec_reached", seen, 1);
        @(posedge clk); #1;
        clear_ctrl();
    endtask

    task automatic check_fetch(input string name, input logic [31:0] exp);
        bit seen;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (seen) chk(name, imem_addr, exp);
        else      chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          hold;
        int          exp_cyc[3];
        logic [31:0] exp_pc[3];

        reset = 0;
        imem_ready = 0;
        imem_rdata = 0;
        clear_ctrl();

        // zero-latency program: addi, addi, ecall
        mem_lat = 0;
        reset_dut();
        vcyc.delete(); vpc.delete();
        exec_inst(0, 0, 0, 0, 0, 32'd1, 0);
        exec_inst(0, 0, 0, 0, 0, 32'd2, 0);
        exec_inst(1, 0, 0, 0, 0, 32'd0, 0);
        repeat (3) @(negedge clk);
        exp_cyc = '{2, 4, 6};
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        chk("t1_valid_count", vcyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (vcyc.size() > i) begin
                chk("t1_valid_cycle", vcyc[i], exp_cyc[i]);
                chk("t1_valid_pc", vpc[i], exp_pc[i]);
            end
        end
        chk("t1_halt_pc", pc, 32'h8);
        chk("t1_retired", retired_count, 3);
        chk("t1_halted", is_halted, 1);
        chk("t1_req_low", imem_req, 0);

        // three wait cycles on every fetch
        mem_lat = 3;
        reset_dut();
        vcyc.delete(); vpc.delete();
        repeat (3) exec_inst(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        exp_cyc = '{5, 10, 15};
        chk("t2_valid_count", vcyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (vcyc.size() > i) chk("t2_valid_cycle", vcyc[i], exp_cyc[i]);
        end
        chk("t2_retired", retired_count, 3);
        chk("t2_pc", pc, 32'hC);

        // control targets around pc=0x10
        mem_lat = 0;
        reset_dut();
        exec_inst(0, 1, 0, 0, 0, 32'h10, 0);
        exec_inst(0, 1, 0, 0, 0, 32'hFFFF_FFF8, 0);
        check_fetch("jal_target", 32'h08);
        exec_inst(0, 1, 0, 0, 0, 32'h8, 0);
        exec_inst(0, 0, 1, 0, 0, 0, 32'h21);
        check_fetch("jalr_target", 32'h20);
        exec_inst(0, 1, 0, 0, 0, 32'hFFFF_FFF0, 0);
        exec_inst(0, 0, 0, 1, 0, 32'h40, 0);
        check_fetch("branch_not_taken", 32'h14);
        exec_inst(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        exec_inst(0, 0, 0, 1, 1, 32'h40, 0);
        check_fetch("branch_taken", 32'h50);
        exec_inst(0, 1, 0, 0, 0, 32'hFFFF_FFC0, 0);
        exec_inst(0, 0, 1, 1, 1, 32'h40, 32'h31);
        check_fetch("jalr_priority", 32'h30);

        // wrap at top of address space
        reset_dut();
        exec_inst(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        check_fetch("wrap_top", 32'hFFFF_FFFC);
        chk("wrap_pc_plus_4", pc_plus_4, 32'h0);
        exec_inst(0, 0, 0, 0, 0, 0, 0);
        check_fetch("wrap_zero", 32'h0);
        chk("wrap_no_flag", pc_misaligned, 0);

        // misaligned jal
        reset_dut();
        exec_inst(0, 1, 0, 0, 0, 32'h6, 0);
        @(negedge clk);
        chk("mis_pc", pc, 32'h6);
        chk("mis_flag", pc_misaligned, 1);
        chk("mis_halted", is_halted, 1);
        chk("mis_retired", retired_count, 1);
        chk("mis_req", imem_req, 0);

        // reset in the middle of a fetch wait, with ready around it
        reset_dut();
        exec_inst(0, 1, 0, 0, 0, 32'h100, 0);
        mem_lat = 6;
        check_fetch("pre_reset_addr", 32'h100);
        repeat (2) @(negedge clk);
        chk("pre_reset_retired", retired_count, 1);
        @(posedge clk); #1 reset = 1; force_ready = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired_count, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_inst", inst, 32'h13);
        @(posedge clk); #1 force_ready = 0; mem_lat = 0;
        @(negedge clk);
        chk("rst_refetch_req", imem_req, 1);
        chk("rst_refetch_addr", imem_addr, 32'h0);

        // randomized traffic
        rand_mode = 1;
        mem_lat = -1;
        for (int it = 0; it < 8; it++) begin
            reset_dut();
            hold = 0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                reset    = ($urandom % 250 == 0);
                is_ecall = ($urandom % 40 == 0);
                is_jal   = ($urandom % 6 == 0);
                is_jalr  = ($urandom % 8 == 0);
                branch   = ($urandom % 4 == 0);
                bcond    = 1'($urandom % 2);
                r        = $urandom;
                imm      = {{20{r[11]}}, r[11:2], ($urandom % 16 == 0), 1'b0};
                alu_result    = $urandom;
                alu_result[1] = ($urandom % 16 == 0);
                if (m_halt) hold++;
                if (hold > 3) break;
            end
            @(posedge clk); #1 reset = 0;
        end
        rand_mode = 0;
        clear_ctrl();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
